// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the SimpleALU datapath.
package alu_pkg;

    // Sequential divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Default divider width and the iteration counter width that goes with it.
    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    // Counter width for an arbitrary divider width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/subtractor.sv
// Unsigned subtractor: diff_o = a_i - b_i, sign_o flags a borrow (a_i < b_i).
module subtractor #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             sign_o
);

    logic [WIDTH:0] w_full;

    // One extra bit catches the borrow out of the MSB.
    always_comb begin
        w_full = {1'b0, a_i} - {1'b0, b_i};
        diff_o = w_full[WIDTH-1:0];
        sign_o = w_full[WIDTH];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake for the ALU DIV operation.
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    // Dividend bits shift out of the MSB while quotient bits shift in at the LSB,
    // so after WIDTH iterations this register holds the quotient.
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_sub_b;
    logic [WIDTH:0]   w_diff;
    logic             w_sign;
    logic             w_borrow;
    logic [WIDTH-1:0] w_next_rem;
    logic [WIDTH-1:0] w_next_shift;

    subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_subtractor (
        .a_i    (w_trial),
        .b_i    (w_sub_b),
        .diff_o (w_diff),
        .sign_o (w_sign)
    );

    // Trial subtraction operands and the restore/keep decision for this iteration.
    always_comb begin
        w_trial      = {r_rem, r_shift[WIDTH-1]};
        w_sub_b      = {1'b0, r_divisor};
        // diff[WIDTH] is only ever set alongside a borrow, so folding it in is a no-op.
        w_borrow     = w_sign | w_diff[WIDTH];
        w_next_rem   = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_next_shift = {r_shift[WIDTH-2:0], ~w_borrow};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_shift   <= dividend_i;
                        r_divisor <= divisor_i;
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        if (divisor_i == '0) begin
                            // No iterations needed: results are final in the very next cycle.
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= dividend_i;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            r_quotient  <= '0;
                            r_remainder <= '0;
                            r_dbz       <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_shift <= w_next_shift;
                    r_rem   <= w_next_rem;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_CNT) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_quotient  <= w_next_shift;
                        r_remainder <= w_next_rem;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy_o        = r_busy;
        done_o        = r_done;
        quotient_o    = r_quotient;
        remainder_o   = r_remainder;
        div_by_zero_o = r_dbz;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands with start; returns just after the accepting edge N.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Number of further clock edges until done_o is seen; -1 on timeout.
    task automatic await_done(output int lat);
        lat = -1;
        for (int j = 0; j < 4 * W; j++) begin
            if (done === 1'b1) begin
                lat = j;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q_ref;
        logic [W-1:0] r_ref;
        q_ref = (b == 0) ? {W{1'b1}} : a / b;
        r_ref = (b == 0) ? a : a % b;
        check({tag, "_q"}, quotient, q_ref);
        check({tag, "_r"}, remainder, r_ref);
        check({tag, "_dbz"}, dbz, (b == 0));
        if (b != 0) begin
            check({tag, "_inv"}, quotient * b + remainder, a);
            check({tag, "_rlt"}, (remainder < b), 1);
        end
    endtask

    // Complete division with latency, pulse width and result checks.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        launch(a, b, 1'b0);
        check({tag, "_busy"}, busy, 1);
        if (b != 0) begin
            check({tag, "_clr_q"}, quotient, 0);
            check({tag, "_clr_dbz"}, dbz, 0);
        end
        await_done(lat);
        check({tag, "_lat"}, lat, (b == 0) ? 0 : W);
        expect_result(tag, a, b);
        check({tag, "_busy_done"}, busy, 1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", dbz, 0);

        run_div("d200_7", 8'd200, 8'd7);
        run_div("d149_210", 8'h95, 8'hD2);
        run_div("d255_1", 8'd255, 8'd1);
        run_div("d37_0", 8'd37, 8'd0);
        run_div("d20_3", 8'd20, 8'd3);

        // start pulsed mid-operation must be ignored
        launch(8'd100, 8'd9, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        dividend = 8'd5;
        divisor  = 8'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        await_done(lat);
        check("mid_lat", lat, W - 3);
        check("mid_q", quotient, 11);
        check("mid_r", remainder, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("hold_q", quotient, 11);
            check("hold_r", remainder, 1);
            check("hold_done", done, 0);
        end

        // synchronous reset in the middle of an operation
        launch(8'd200, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_q", quotient, 0);
        check("mrst_r", remainder, 0);
        check("mrst_dbz", dbz, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 2 * W; i++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) seen++;
            end
            check("mrst_no_done", seen, 0);
        end
        run_div("d50_5", 8'd50, 8'd5);

        // start held high: next acceptance at edge N+W+2
        launch(8'd77, 8'd6, 1'b1);
        dividend = 8'd90;
        divisor  = 8'd4;
        await_done(lat);
        check("b2b_lat", lat, W);
        expect_result("b2b_first", 8'd77, 8'd6);
        @(posedge clk);
        #1;
        check("b2b_gap", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_reaccept", busy, 1);
        await_done(lat);
        check("b2b_lat2", lat, W);
        expect_result("b2b_second", 8'd90, 8'd4);
        @(posedge clk);
        #1;

        // random operands with edge values mixed in
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case (i % 16)
                0: a = '0;
                1: a = '1;
                2: b = '0;
                3: b = '1;
                4: b = 8'd1;
                5: begin a = '1; b = 8'd1; end
                default: ;
            endcase
            run_div("rnd", a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
